csr_trap_ctrl: RTL
==================

// Module: csr_trap_ctrl
// PURPOSE
//  Machine-mode CSR register file plus trap/return sequencer for the NPC core.
//  Holds mstatus, mie, mtvec, mepc, mcause and mip; executes CSRRW/RS/RC, ECALL, MRET and the timer interrupt.
//  Sits beside EXU: accepts one request at a time via valid/ready.
//  Returns the old CSR value, or a redirect PC to IFU.
// PARAMETERS
//  XLEN      64  data/PC width
//  MTVEC_RST 0   reset value of mtvec
//  IRQ_EN    1   0 = timer interrupt never taken (mip still tracks timer_irq)
// PORTS
//  clk            in   1     core clock, rising edge
//  rst_n          in   1     asynchronous reset, active low
//  req_valid      in   1     request present
//  req_ready      out  1     1 only in IDLE
//  req_op         in   3     0 NONE, 1 RW, 2 RS, 3 RC, 4 ECALL, 5 MRET; 6,7 treated as NONE
//  req_csr        in   12    CSR address
//  req_wdata      in   XLEN  rs1/uimm operand
//  req_pc         in   XLEN  PC of the requesting instruction
//  timer_irq      in   1     level timer interrupt from CLINT
//  rsp_valid      out  1     1-cycle pulse: rsp_rdata valid
//  rsp_rdata      out  XLEN  CSR value before the write
//  illegal_csr    out  1     pulses with rsp_valid for an unmapped address
//  redirect_valid out  1     1-cycle pulse: IFU must fetch from redirect_pc
//  redirect_pc    out  XLEN  trap vector or mepc
// BEHAVIOUR
//  Reset:
//   - mstatus=0x1800 (MPP=11); mie=0; mtvec=MTVEC_RST; mepc=0; mcause=0; mip=0; state=IDLE.
//   - All outputs 0 except req_ready=1.
//  Address decode:
//   - 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x344 mip.
//   - Any other address is unmapped: rdata=0, illegal_csr=1, no state change.
//  Write masks:
//   - mstatus writable bits are 3 (MIE) and 7 (MPIE); MPP always reads 11.
//   - mtvec[1:0] are forced to 00.
//   - mip is read-only; bit 7 (MTIP) samples timer_irq every cycle.
//  CSR ops (RW/RS/RC), handshake at cycle 0:
//   - Cycle 1: rsp_valid=1, rsp_rdata=old value.
//   - New value is visible from cycle 1: RW=wdata, RS=old|wdata, RC=old&~wdata.
//   - RS/RC with wdata=0 leave the CSR unchanged.
//  FSM states: IDLE, CSR_RSP, TRAP_SAVE, TRAP_STAT, MRET_STAT, REDIRECT.
//   - IDLE -> CSR_RSP (RW/RS/RC) -> IDLE.
//   - IDLE -> TRAP_SAVE -> TRAP_STAT -> REDIRECT -> IDLE (ECALL or interrupt).
//   - IDLE -> MRET_STAT -> REDIRECT -> IDLE (MRET).
//   - req_op NONE: accepted, no effect, no response.
//  Trap entry:
//   - TRAP_SAVE: mepc<=captured pc; mcause<=11 (ECALL) or (1<<(XLEN-1))|7 (interrupt).
//   - TRAP_STAT: MPIE<=MIE, MIE<=0.
//   - REDIRECT: redirect_pc=mtvec.
//   - ECALL handshake at cycle 0 gives redirect_valid at cycle 3.
//  MRET:
//   - MRET_STAT: MIE<=MPIE, MPIE<=1.
//   - REDIRECT: redirect_pc=mepc. Handshake at cycle 0 gives redirect_valid at cycle 2.
//  Interrupt take condition, in IDLE:
//   - IRQ_EN & mstatus.MIE & mie[7] & mip[7] & req_valid.
//   - Overrides any req_op, ECALL included: the request is consumed, not executed, and req_pc is saved as mepc.
//  Boundaries:
//   - timer_irq rising mid-sequence is deferred to the next IDLE handshake.
//   - A CSR write to mstatus.MIE takes effect for the next request.
//   - Reset mid-sequence aborts to IDLE: no redirect or rsp pulse, and CSRs take reset values.
//   - redirect_valid and rsp_valid are never both high.
// STRUCTURE
//  - csr_pkg holds: CSR address localparams, index enum, op encodings (CSR_OP_*), FSM state typedef, MSTATUS_WMASK, MCAUSE_* constants.
//  - Sub-module csr_trap_fsm holds the state register, next-state logic and the captured pc/cause regs.
//  - The top level holds the CSR registers, decode and read mux.
// TESTING
//  - Reset, then read 0x300 via RS with wdata=0 -> rdata=0x1800; read 0x305 -> MTVEC_RST.
//  - RW 0x305 wdata=0x8000_0103 -> rsp old value; a following RS read -> 0x8000_0100.
//  - mtvec=0x8000_0100, ECALL at pc=0x8000_0040 -> redirect_pc=0x8000_0100 at cycle 3; mepc=0x8000_0040; mcause=11; MIE=0, MPIE=prior MIE.
//  - Following MRET -> redirect_pc=0x8000_0040 at cycle 2; MIE restored; MPIE=1.
//  - mie=0x80, MIE=1, timer_irq=1, ECALL valid at pc=0x8000_0080 -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0080.
//  - RW to 0x7C0 -> illegal_csr=1, rdata=0, no CSR changed; rst_n low in TRAP_STAT -> no redirect_valid, req_ready=1.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, request opcodes, FSM states and fixed CSR field values.
package csr_pkg;

    localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ADDR_MIE     = 12'h304;
    localparam logic [11:0] CSR_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_ADDR_MIP     = 12'h344;

    typedef enum logic [2:0] {
        CSR_IDX_MSTATUS = 3'd0,
        CSR_IDX_MIE     = 3'd1,
        CSR_IDX_MTVEC   = 3'd2,
        CSR_IDX_MEPC    = 3'd3,
        CSR_IDX_MCAUSE  = 3'd4,
        CSR_IDX_MIP     = 3'd5,
        CSR_IDX_NONE    = 3'd6
    } csr_idx_e;

    localparam logic [2:0] CSR_OP_NONE  = 3'd0;
    localparam logic [2:0] CSR_OP_RW    = 3'd1;
    localparam logic [2:0] CSR_OP_RS    = 3'd2;
    localparam logic [2:0] CSR_OP_RC    = 3'd3;
    localparam logic [2:0] CSR_OP_ECALL = 3'd4;
    localparam logic [2:0] CSR_OP_MRET  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CSR_RSP   = 3'd1,
        ST_TRAP_SAVE = 3'd2,
        ST_TRAP_STAT = 3'd3,
        ST_MRET_STAT = 3'd4,
        ST_REDIRECT  = 3'd5
    } trap_state_e;

    // mstatus keeps only MIE/MPIE as state; MPP is hardwired to machine mode.
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
    localparam logic [63:0] MSTATUS_FIXED = 64'h0000_0000_0000_1800;
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIP_MTIP_BIT     = 7;

    localparam int unsigned MCAUSE_ECALL_M  = 32'd11;
    localparam int unsigned MCAUSE_MTI_CODE = 32'd7;

    function automatic csr_idx_e csr_decode(input logic [11:0] addr);
        case (addr)
            CSR_ADDR_MSTATUS: csr_decode = CSR_IDX_MSTATUS;
            CSR_ADDR_MIE:     csr_decode = CSR_IDX_MIE;
            CSR_ADDR_MTVEC:   csr_decode = CSR_IDX_MTVEC;
            CSR_ADDR_MEPC:    csr_decode = CSR_IDX_MEPC;
            CSR_ADDR_MCAUSE:  csr_decode = CSR_IDX_MCAUSE;
            CSR_ADDR_MIP:     csr_decode = CSR_IDX_MIP;
            default:          csr_decode = CSR_IDX_NONE;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_fsm.sv
// Request sequencer: accepts one request in IDLE and walks the CSR,
// trap-entry and MRET sequences, capturing the trap pc and cause.
module csr_trap_fsm
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_pc,
    input  logic            irq_pending,
    output logic            req_ready,
    output logic            csr_fire,
    output logic            trap_save,
    output logic            trap_stat,
    output logic            mret_stat,
    output logic            enter_redirect,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_cause
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;

    // State and captured trap context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic; a pending interrupt hijacks whatever request is offered.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && irq_pending) begin
                    state_d = ST_TRAP_SAVE;
                    epc_d   = req_pc;
                    cause_d = {1'b1, (XLEN-1)'(MCAUSE_MTI_CODE)};
                end else if (req_valid) begin
                    case (req_op)
                        CSR_OP_RW, CSR_OP_RS, CSR_OP_RC: state_d = ST_CSR_RSP;
                        CSR_OP_ECALL: begin
                            state_d = ST_TRAP_SAVE;
                            epc_d   = req_pc;
                            cause_d = XLEN'(MCAUSE_ECALL_M);
                        end
                        CSR_OP_MRET: state_d = ST_MRET_STAT;
                        default:     state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CSR_RSP:   state_d = ST_IDLE;
            ST_TRAP_SAVE: state_d = ST_TRAP_STAT;
            ST_TRAP_STAT: state_d = ST_REDIRECT;
            ST_MRET_STAT: state_d = ST_REDIRECT;
            ST_REDIRECT:  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Per-state strobes consumed by the CSR datapath.
    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        csr_fire       = (state_q == ST_IDLE) && (state_d == ST_CSR_RSP);
        trap_save      = (state_q == ST_TRAP_SAVE);
        trap_stat      = (state_q == ST_TRAP_STAT);
        mret_stat      = (state_q == ST_MRET_STAT);
        enter_redirect = (state_d == ST_REDIRECT);
        trap_epc       = epc_q;
        trap_cause     = cause_q;
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR register file (mstatus, mie, mtvec, mepc, mcause, mip)
// with CSRRW/RS/RC, ECALL, MRET and timer-interrupt trap handling.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter bit              IRQ_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_csr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [XLEN-1:0] req_pc,
    input  logic            timer_irq,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            illegal_csr,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mip_q, mip_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            illegal_csr_q, illegal_csr_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            irq_pending;
    logic            csr_fire, trap_save, trap_stat, mret_stat, enter_redirect;
    logic [XLEN-1:0] trap_epc, trap_cause;
    csr_idx_e        csr_idx;
    logic [XLEN-1:0] old_val, new_val;

    assign irq_pending = IRQ_EN && mstatus_q[MSTATUS_MIE_BIT]
                         && mie_q[MIP_MTIP_BIT] && mip_q[MIP_MTIP_BIT];

    csr_trap_fsm #(
        .XLEN(XLEN)
    ) u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_pc        (req_pc),
        .irq_pending   (irq_pending),
        .req_ready     (req_ready),
        .csr_fire      (csr_fire),
        .trap_save     (trap_save),
        .trap_stat     (trap_stat),
        .mret_stat     (mret_stat),
        .enter_redirect(enter_redirect),
        .trap_epc      (trap_epc),
        .trap_cause    (trap_cause)
    );

    // Address decode, old-value read mux and read-modify-write result.
    always_comb begin
        csr_idx = csr_decode(req_csr);
        old_val = '0;
        case (csr_idx)
            CSR_IDX_MSTATUS: old_val = mstatus_q;
            CSR_IDX_MIE:     old_val = mie_q;
            CSR_IDX_MTVEC:   old_val = mtvec_q;
            CSR_IDX_MEPC:    old_val = mepc_q;
            CSR_IDX_MCAUSE:  old_val = mcause_q;
            CSR_IDX_MIP:     old_val = mip_q;
            default:         old_val = '0;
        endcase
        case (req_op)
            CSR_OP_RW: new_val = req_wdata;
            CSR_OP_RS: new_val = old_val | req_wdata;
            CSR_OP_RC: new_val = old_val & ~req_wdata;
            default:   new_val = old_val;
        endcase
    end

    // CSR next-state: software writes, trap entry and MRET stack updates.
    always_comb begin
        mstatus_d = mstatus_q;
        mie_d     = mie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mip_d     = '0;
        mip_d[MIP_MTIP_BIT] = timer_irq;
        if (csr_fire) begin
            case (csr_idx)
                CSR_IDX_MSTATUS: mstatus_d = XLEN'(MSTATUS_FIXED) | (new_val & XLEN'(MSTATUS_WMASK));
                CSR_IDX_MIE:     mie_d     = new_val;
                CSR_IDX_MTVEC:   mtvec_d   = {new_val[XLEN-1:2], 2'b00};
                CSR_IDX_MEPC:    mepc_d    = new_val;
                CSR_IDX_MCAUSE:  mcause_d  = new_val;
                default:         mepc_d    = mepc_q;
            endcase
        end else if (trap_save) begin
            mepc_d   = trap_epc;
            mcause_d = trap_cause;
        end else if (trap_stat) begin
            mstatus_d[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
            mstatus_d[MSTATUS_MIE_BIT]  = 1'b0;
        end else if (mret_stat) begin
            mstatus_d[MSTATUS_MIE_BIT]  = mstatus_q[MSTATUS_MPIE_BIT];
            mstatus_d[MSTATUS_MPIE_BIT] = 1'b1;
        end else begin
            mstatus_d = mstatus_q;
        end
    end

    // Output pulses are registered so they line up with the FSM state they report.
    always_comb begin
        rsp_valid_d      = csr_fire;
        rsp_rdata_d      = csr_fire ? old_val : '0;
        illegal_csr_d    = csr_fire && (csr_idx == CSR_IDX_NONE);
        redirect_valid_d = enter_redirect;
        if (enter_redirect) begin
            redirect_pc_d = mret_stat ? mepc_q : mtvec_q;
        end else begin
            redirect_pc_d = '0;
        end
    end

    // CSR state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q <= XLEN'(MSTATUS_FIXED);
            mie_q     <= '0;
            mtvec_q   <= MTVEC_RST;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mip_q     <= '0;
        end else begin
            mstatus_q <= mstatus_d;
            mie_q     <= mie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mip_q     <= mip_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            illegal_csr_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
            illegal_csr_q    <= illegal_csr_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign illegal_csr    = illegal_csr_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule
